vagas_encoder: RTL

Counts free parking spaces from the per-space presence sensors and emits the count as a BCD code for the 7-segment display decoder. Raw sensor lines are synchronized and debounced. A round-robin scan FSM sweeps all spaces and tallies the free ones. The result is published as a registered units nibble (A,B,C,D), a tens bit, a lot-full flag and a one-cycle update pulse. The block sits between the sensor pins and the display decoder; its A..D outputs drive the decoder's A..D inputs directly.

---
 rtl/vagas_encoder_pkg.sv | 9 +
 rtl/vagas_encoder_if.sv | 7 +
 rtl/vagas_debounce.sv | 35 +++
 rtl/vagas_encoder.sv | 73 +++++++
 4 files changed

// File: rtl/vagas_encoder_pkg.sv
// vagas_encoder_pkg: shared scan-state encodings, BCD threshold and space limit for vagas_encoder
package vagas_encoder_pkg;
  typedef enum logic {SCAN = 1'b0, PUBLISH = 1'b1} scan_state_t;
  localparam int BCD_TEN = 10;
  localparam int MAX_SPOTS = 15;
  function automatic logic [4:0] to_bcd(input logic [3:0] n);
    return (n >= 4'(BCD_TEN)) ? {1'b1, n - 4'(BCD_TEN)} : {1'b0, n};
  endfunction
endpackage

// File: rtl/vagas_encoder_if.sv
// vagas_encoder_if: sensor lines in, BCD digit / status flags out
interface vagas_encoder_if #(parameter int N_SPOTS = 8);
  logic [N_SPOTS-1:0] sensor;
  logic A, B, C, D, dez, lotado, upd;
  modport master (output sensor, input A, B, C, D, dez, lotado, upd);
  modport slave (input sensor, output A, B, C, D, dez, lotado, upd);
endinterface

// File: rtl/vagas_debounce.sv
// vagas_debounce: 2-flop sync plus optional debounce of one sensor line (VAGAS_DEBOUNCE_EN)
module vagas_debounce #(
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);
  logic s1, s2;
  if (DEBOUNCE_CYC < 1) begin : g_bad_cyc
    $error("DEBOUNCE_CYC must be at least 1");
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {s2, s1} <= 2'b00;
    else {s2, s1} <= {s1, raw};
`ifdef VAGAS_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  logic [CW-1:0] cnt;
  logic acc;
  // accept the new level on the DEBOUNCE_CYC-th consecutive differing cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      acc <= 1'b0;
    end else if (s2 == acc) cnt <= '0;
    else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
      acc <= s2;
      cnt <= '0;
    end else cnt <= cnt + 1'b1;
  assign level = acc;
`else
  assign level = s2;
`endif
endmodule

// File: rtl/vagas_encoder.sv
// vagas_encoder: free-space counter with BCD output; debounce enabled by VAGAS_DEBOUNCE_EN
module vagas_encoder
  import vagas_encoder_pkg::*;
#(
  parameter int N_SPOTS = 8,
  parameter int DEBOUNCE_CYC = 16
) (
  input logic clk,
  input logic rst_n,
  vagas_encoder_if.slave bus
);
  localparam logic [3:0] LAST = 4'(N_SPOTS - 1);
  if (N_SPOTS < 1 || N_SPOTS > MAX_SPOTS) begin : g_bad_spots
    $error("N_SPOTS out of range");
  end
  logic [N_SPOTS-1:0] level;
  logic [15:0] lvl_pad;
  scan_state_t state, state_n;
  logic [3:0] idx, idx_n, acc, acc_n, digit, digit_n, prev, prev_n;
  logic dez, dez_n, lotado, lotado_n, upd, upd_n;
  for (genvar i = 0; i < N_SPOTS; i++) begin : g_deb
    vagas_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb (
      .clk(clk), .rst_n(rst_n), .raw(bus.sensor[i]), .level(level[i])
    );
  end
  assign lvl_pad = 16'(level);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= SCAN;
      idx <= '0;
      acc <= '0;
      digit <= '0;
      prev <= '0;
      dez <= 1'b0;
      lotado <= 1'b0;
      upd <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      acc <= acc_n;
      digit <= digit_n;
      prev <= prev_n;
      dez <= dez_n;
      lotado <= lotado_n;
      upd <= upd_n;
    end
  always_comb begin
    state_n = state;
    idx_n = idx;
    acc_n = acc;
    {dez_n, digit_n} = {dez, digit};
    lotado_n = lotado;
    prev_n = prev;
    upd_n = 1'b0;
    if (state == SCAN) begin
      acc_n = acc + {3'b000, ~lvl_pad[idx]};
      idx_n = (idx == LAST) ? idx : idx + 4'd1;
      state_n = (idx == LAST) ? PUBLISH : SCAN;
    end else begin
      {dez_n, digit_n} = to_bcd(acc);
      lotado_n = (acc == 4'd0);
      upd_n = (acc != prev);
      prev_n = acc;
      acc_n = '0;
      idx_n = '0;
      state_n = SCAN;
    end
  end
  assign {bus.A, bus.B, bus.C, bus.D} = digit;
  assign bus.dez = dez;
  assign bus.lotado = lotado;
  assign bus.upd = upd;
endmodule
